des3_wb_master: RTL and testbench

Wishbone classic-cycle bus initiator that drives the DES3 core's memory-mapped register block on behalf of a local client. It accepts one job (64-bit block, three 56-bit keys, direction) over a valid/ready handshake. It then loads the core's registers, pulses start, polls the output-valid register, reads back the 64-bit result and presents it over a second valid/ready handshake. It sits between a DMA/command engine and the DES3 Wishbone slave, with no CPU involvement per block.

---
 rtl/des3_wb_master.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_des3_wb_master.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des3_wb_master.sv
// Wishbone classic-cycle initiator that runs one DES3 job: it loads the core registers,
// polls for completion and returns the result. Optional poll timeout: DES3_WBM_TIMEOUT_EN.
module des3_wb_master #(
  parameter int          aw         = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          POLL_LIMIT = 1024
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n_i,
  input  logic          job_valid_i,
  output logic          job_ready_o,
  input  logic          job_decrypt_i,
  input  logic [63:0]   job_data_i,
  input  logic [55:0]   job_key1_i,
  input  logic [55:0]   job_key2_i,
  input  logic [55:0]   job_key3_i,
  output logic          res_valid_o,
  input  logic          res_ready_i,
  output logic [63:0]   res_data_o,
  output logic          res_err_o,
  output logic          busy_o,
  output logic [aw-1:0] wb_adr_o,
  output logic [31:0]   wb_dat_o,
  input  logic [31:0]   wb_dat_i,
  output logic [3:0]    wb_sel_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  input  logic          wb_ack_i,
  input  logic          wb_err_i
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_POLL  = 3'd2,
    S_RD_HI = 3'd3,
    S_RD_LO = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    step_q, step_d;
  logic          dec_q, dec_d;
  logic [63:0]   data_q, data_d;
  logic [55:0]   key1_q, key1_d, key2_q, key2_d, key3_q, key3_d;
  logic [31:0]   res_hi_q, res_hi_d;
  logic          job_ready_q, job_ready_d;
  logic          busy_q, busy_d;
  logic          res_valid_q, res_valid_d;
  logic          res_err_q, res_err_d;
  logic [63:0]   res_data_q, res_data_d;
  logic          cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [aw-1:0] adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [35:0]   entry_s;
  logic          bus_err_s;
`ifdef DES3_WBM_TIMEOUT_EN
  logic [31:0]   poll_cnt_q, poll_cnt_d;
`endif

  function automatic logic [aw-1:0] reg_addr(input logic [3:0] idx);
    logic [31:0] a;
    a = BASE_ADDR + {26'd0, idx, 2'b00};
    return aw'(a);
  endfunction

  // Write schedule: {register index, write data} for each step of the load phase.
  function automatic logic [35:0] wr_entry(input logic [3:0] step, input logic dec,
                                           input logic [63:0] data, input logic [55:0] k1,
                                           input logic [55:0] k2, input logic [55:0] k3);
    logic [35:0] e;
    case (step)
      4'd0:    e = {4'd1, 31'd0, dec};
      4'd1:    e = {4'd2, data[31:0]};
      4'd2:    e = {4'd3, data[63:32]};
      4'd3:    e = {4'd4, 4'd0, k3[27:0]};
      4'd4:    e = {4'd5, 4'd0, k3[55:28]};
      4'd5:    e = {4'd6, 4'd0, k2[27:0]};
      4'd6:    e = {4'd7, 4'd0, k2[55:28]};
      4'd7:    e = {4'd8, 4'd0, k1[27:0]};
      4'd8:    e = {4'd9, 4'd0, k1[55:28]};
      4'd9:    e = {4'd0, 32'd1};
      default: e = {4'd0, 32'd0};
    endcase
    return e;
  endfunction

  assign bus_err_s = cyc_q && stb_q && wb_err_i;

  // Next-state, bus and handshake decode
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    dec_d       = dec_q;
    data_d      = data_q;
    key1_d      = key1_q;
    key2_d      = key2_q;
    key3_d      = key3_q;
    res_hi_d    = res_hi_q;
    job_ready_d = job_ready_q;
    busy_d      = busy_q;
    res_valid_d = res_valid_q;
    res_err_d   = res_err_q;
    res_data_d  = res_data_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
`ifdef DES3_WBM_TIMEOUT_EN
    poll_cnt_d  = poll_cnt_q;
`endif
    entry_s     = wr_entry(step_q + 4'd1, dec_q, data_q, key1_q, key2_q, key3_q);
    if (bus_err_s) begin
      // Error wins over a simultaneous ack.
      state_d     = S_RESP;
      cyc_d       = 1'b0;
      stb_d       = 1'b0;
      we_d        = 1'b0;
      res_valid_d = 1'b1;
      res_err_d   = 1'b1;
      res_data_d  = 64'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (job_valid_i) begin
            dec_d       = job_decrypt_i;
            data_d      = job_data_i;
            key1_d      = job_key1_i;
            key2_d      = job_key2_i;
            key3_d      = job_key3_i;
            state_d     = S_WR;
            step_d      = 4'd0;
            job_ready_d = 1'b0;
            busy_d      = 1'b1;
            res_err_d   = 1'b0;
            cyc_d       = 1'b1;
            stb_d       = 1'b1;
            we_d        = 1'b1;
            adr_d       = reg_addr(4'd1);
            dat_d       = {31'd0, job_decrypt_i};
          end else begin
            job_ready_d = 1'b1;
          end
        end
        S_WR: begin
          if (wb_ack_i && (step_q == 4'd10)) begin
            state_d = S_POLL;
            we_d    = 1'b0;
            adr_d   = reg_addr(4'd10);
            dat_d   = 32'd0;
`ifdef DES3_WBM_TIMEOUT_EN
            poll_cnt_d = 32'd0;
`endif
          end else if (wb_ack_i) begin
            step_d = step_q + 4'd1;
            adr_d  = reg_addr(entry_s[35:32]);
            dat_d  = entry_s[31:0];
          end else begin
            step_d = step_q;
          end
        end
        S_POLL: begin
          if (wb_ack_i && wb_dat_i[0]) begin
            state_d = S_RD_HI;
            adr_d   = reg_addr(4'd11);
          end else if (wb_ack_i) begin
`ifdef DES3_WBM_TIMEOUT_EN
            if (poll_cnt_q == 32'(POLL_LIMIT - 1)) begin
              state_d     = S_RESP;
              cyc_d       = 1'b0;
              stb_d       = 1'b0;
              res_valid_d = 1'b1;
              res_err_d   = 1'b1;
              res_data_d  = 64'd0;
            end else begin
              poll_cnt_d = poll_cnt_q + 32'd1;
            end
`else
            state_d = S_POLL;
`endif
          end else begin
            state_d = S_POLL;
          end
        end
        S_RD_HI: begin
          if (wb_ack_i) begin
            res_hi_d = wb_dat_i;
            state_d  = S_RD_LO;
            adr_d    = reg_addr(4'd12);
          end else begin
            state_d = S_RD_HI;
          end
        end
        S_RD_LO: begin
          if (wb_ack_i) begin
            res_data_d  = {res_hi_q, wb_dat_i};
            res_valid_d = 1'b1;
            res_err_d   = 1'b0;
            cyc_d       = 1'b0;
            stb_d       = 1'b0;
            state_d     = S_RESP;
          end else begin
            state_d = S_RD_LO;
          end
        end
        S_RESP: begin
          if (res_ready_i) begin
            res_valid_d = 1'b0;
            res_err_d   = 1'b0;
            busy_d      = 1'b0;
            job_ready_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            state_d = S_RESP;
          end
        end
        default: begin
          state_d     = S_IDLE;
          job_ready_d = 1'b1;
          busy_d      = 1'b0;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
        end
      endcase
    end
  end

  // State, job and output registers with synchronous active-low reset
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= S_IDLE;
      step_q      <= 4'd0;
      dec_q       <= 1'b0;
      data_q      <= 64'd0;
      key1_q      <= 56'd0;
      key2_q      <= 56'd0;
      key3_q      <= 56'd0;
      res_hi_q    <= 32'd0;
      job_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      res_data_q  <= 64'd0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= 32'd0;
`ifdef DES3_WBM_TIMEOUT_EN
      poll_cnt_q  <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      dec_q       <= dec_d;
      data_q      <= data_d;
      key1_q      <= key1_d;
      key2_q      <= key2_d;
      key3_q      <= key3_d;
      res_hi_q    <= res_hi_d;
      job_ready_q <= job_ready_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_err_q   <= res_err_d;
      res_data_q  <= res_data_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
`ifdef DES3_WBM_TIMEOUT_EN
      poll_cnt_q  <= poll_cnt_d;
`endif
    end
  end

  assign job_ready_o = job_ready_q;
  assign busy_o      = busy_q;
  assign res_valid_o = res_valid_q;
  assign res_err_o   = res_err_q;
  assign res_data_o  = res_data_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = stb_q;
  assign wb_we_o     = we_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = 4'hF;

endmodule

// File: tb/tb_des3_wb_master.sv
// Self-checking bench for des3_wb_master: table of jobs against a behavioural DES3 slave,
// plus hand-written error, backpressure, reset and (with DES3_WBM_TIMEOUT_EN) timeout sequences.
module tb_des3_wb_master;

  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        job_valid, job_ready, job_decrypt;
  logic [63:0] job_data;
  logic [55:0] job_key1, job_key2, job_key3;
  logic        res_valid, res_ready, res_err, busy;
  logic [63:0] res_data;
  logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel;
  logic        wb_cyc, wb_stb, wb_we, wb_ack, wb_err;

  always #5 clk = ~clk;

  des3_wb_master #(.aw(32), .BASE_ADDR(BASE), .POLL_LIMIT(8)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .job_valid_i(job_valid), .job_ready_o(job_ready), .job_decrypt_i(job_decrypt),
    .job_data_i(job_data), .job_key1_i(job_key1), .job_key2_i(job_key2), .job_key3_i(job_key3),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data), .res_err_o(res_err),
    .busy_o(busy), .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_ack_i(wb_ack), .wb_err_i(wb_err)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } tx_t;

  // wr holds the 11 expected write words, step 0 in the most significant slot.
  typedef struct {
    logic             dec;
    logic [63:0]      data;
    logic [55:0]      k1, k2, k3;
    int               valid_on;
    bit               waits;
    logic [63:0]      res;
    logic [10:0][31:0] wr;
    int               exp_cyc;
  } vec_t;

  vec_t        vecs [3];
  logic [31:0] wr_off [11];
  tx_t         log_q [$];
  int          checks = 0;
  int          errors = 0;

  int          valid_on = 0;
  logic [31:0] mres_hi = 32'd0, mres_lo = 32'd0;
  bit          use_waits = 1'b0, err_arm = 1'b0;
  int          poll_done = 0, wait_cnt = 0, wait_tgt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural DES3 slave: status bit0 rises on poll number valid_on, optional wait states
  always_comb begin
    wb_err = err_arm && wb_cyc && wb_stb && wb_we && (wb_adr == BASE + 32'd24);
    wb_ack = wb_cyc && wb_stb && !wb_err && (!use_waits || (wait_cnt >= wait_tgt));
    if (wb_adr == BASE + 32'd40)
      wb_dat_i = {31'd0, (valid_on != 0) && (poll_done + 1 >= valid_on)};
    else if (wb_adr == BASE + 32'd44)
      wb_dat_i = mres_hi;
    else if (wb_adr == BASE + 32'd48)
      wb_dat_i = mres_lo;
    else
      wb_dat_i = 32'd0;
  end

  always @(posedge clk) begin
    if (wb_cyc && wb_stb && (wb_ack || wb_err)) begin
      wait_cnt <= 0;
      wait_tgt <= use_waits ? int'($urandom_range(0, 3)) : 0;
    end else if (wb_cyc && wb_stb) begin
      wait_cnt <= wait_cnt + 1;
    end
    if (wb_ack) begin
      log_q.push_back({wb_we, wb_adr, wb_dat_o});
      if (!wb_we && wb_adr == BASE + 32'd40) poll_done <= poll_done + 1;
      if (wb_we && wb_adr == BASE && wb_dat_o == 32'd1) poll_done <= 0;
    end
  end

  // Bus signals must not move while the slave is stalling
  logic        st_prev = 1'b0;
  logic [31:0] p_adr, p_dat;
  logic        p_we;
  always @(negedge clk) begin
    if (st_prev) begin
      check("hold_adr", wb_adr, p_adr);
      check("hold_dat", wb_dat_o, p_dat);
      check("hold_we_stb", {wb_we, wb_cyc, wb_stb}, {p_we, 2'b11});
    end
    st_prev <= wb_cyc && wb_stb && !wb_ack && !wb_err;
    p_adr   <= wb_adr;
    p_dat   <= wb_dat_o;
    p_we    <= wb_we;
  end

  task automatic set_model(input int i);
    valid_on  = vecs[i].valid_on;
    mres_hi   = vecs[i].res[63:32];
    mres_lo   = vecs[i].res[31:0];
    use_waits = vecs[i].waits;
  endtask

  task automatic drive_job(input int i);
    job_decrypt = vecs[i].dec;
    job_data    = vecs[i].data;
    job_key1    = vecs[i].k1;
    job_key2    = vecs[i].k2;
    job_key3    = vecs[i].k3;
  endtask

  task automatic start_job(input int i);
    drive_job(i);
    log_q.delete();
    job_valid = 1'b1;
    @(posedge clk);
    #1 job_valid = 1'b0;
  endtask

  task automatic wait_res(output int c);
    bit ok;
    ok = 1'b0;
    c  = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      c++;
      if (res_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("res_timeout", {63'd0, ok}, 64'd1);
  endtask

  task automatic take_res();
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    check("after_take", {res_valid, job_ready, busy}, {1'b0, 1'b1, 1'b0});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hs"}, {job_ready, res_valid, res_err, busy}, {1'b1, 1'b0, 1'b0, 1'b0});
    check({tag, "_bus"}, {wb_cyc, wb_stb, wb_we, wb_sel}, {1'b0, 1'b0, 1'b0, 4'hF});
    check({tag, "_adr_dat"}, {wb_adr, wb_dat_o}, 64'd0);
    check({tag, "_res_data"}, res_data, 64'd0);
  endtask

  task automatic run_vec(input int i, input bit take);
    int  c, n;
    tx_t t;
    set_model(i);
    start_job(i);
    wait_res(c);
    if (vecs[i].exp_cyc != 0) check("res_cycle", c, vecs[i].exp_cyc);
    check("res_data", res_data, vecs[i].res);
    check("res_flags", {res_err, busy, job_ready, wb_cyc, wb_stb}, {1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    n = 13 + vecs[i].valid_on;
    check("tx_count", log_q.size(), n);
    for (int j = 0; j < n && j < log_q.size(); j++) begin
      t = log_q[j];
      if (j < 11) begin
        check("tx_wr_adr", {t.we, t.adr}, {1'b1, BASE + wr_off[j]});
        check("tx_wr_dat", t.dat, vecs[i].wr[10-j]);
      end else if (j < 11 + vecs[i].valid_on) begin
        check("tx_poll_adr", {t.we, t.adr}, {1'b0, BASE + 32'd40});
      end else if (j == 11 + vecs[i].valid_on) begin
        check("tx_rdhi_adr", {t.we, t.adr}, {1'b0, BASE + 32'd44});
      end else begin
        check("tx_rdlo_adr", {t.we, t.adr}, {1'b0, BASE + 32'd48});
      end
    end
    if (take) take_res();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  c;
    bit  bad;
    wr_off = '{32'd4, 32'd8, 32'd12, 32'd16, 32'd20, 32'd24, 32'd28, 32'd32, 32'd36, 32'd0, 32'd0};
    vecs[0] = '{1'b0, 64'h0123456789ABCDEF, 56'h0123456789ABCD, 56'h23456789ABCDEF,
                56'h456789ABCDEF01, 3, 1'b0, 64'hCAFEF00DDEADBEEF,
                {32'h00000000, 32'h89ABCDEF, 32'h01234567, 32'h0BCDEF01, 32'h0456789A, 32'h09ABCDEF,
                 32'h02345678, 32'h0789ABCD, 32'h00123456, 32'h00000001, 32'h00000000}, 17};
    vecs[1] = '{1'b1, 64'hFFFFFFFF00000000, 56'hFFFFFFFFFFFFFF, 56'h0, 56'hF0000001000000,
                1, 1'b0, 64'h1122334455667788,
                {32'h00000001, 32'h00000000, 32'hFFFFFFFF, 32'h01000000, 32'h0F000000, 32'h00000000,
                 32'h00000000, 32'h0FFFFFFF, 32'h0FFFFFFF, 32'h00000001, 32'h00000000}, 15};
    vecs[2] = '{1'b0, 64'hA5A5A5A55A5A5A5A, 56'h00000000000001, 56'h10000000000000,
                56'h0000000FFFFFFF, 2, 1'b1, 64'hDEADBEEFCAFEF00D,
                {32'h00000000, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'h0FFFFFFF, 32'h00000000, 32'h00000000,
                 32'h01000000, 32'h00000001, 32'h00000000, 32'h00000001, 32'h00000000}, 0};

    rst_n = 1'b0; job_valid = 1'b0; res_ready = 1'b0;
    drive_job(0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) run_vec(i, 1'b1);

    // Bus error on the step-5 write, then a clean job
    set_model(0);
    err_arm = 1'b1;
    start_job(0);
    wait_res(c);
    check("err_cycle", c, 7);
    check("err_flags", {wb_cyc, wb_stb, res_err}, {1'b0, 1'b0, 1'b1});
    check("err_data", res_data, 64'd0);
    check("err_tx_count", log_q.size(), 5);
    err_arm = 1'b0;
    take_res();
    run_vec(0, 1'b1);

    // Result backpressure with a competing job offer
    run_vec(1, 1'b0);
    set_model(0);
    drive_job(0);
    job_valid = 1'b1;
    bad = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!res_valid || res_data !== vecs[1].res || job_ready || wb_cyc) bad = 1'b1;
    end
    check("bp_hold", {63'd0, bad}, 64'd0);
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    check("bp_release", {job_ready, res_valid, wb_cyc}, {1'b1, 1'b0, 1'b0});
    @(negedge clk);
    check("bp_accept", {job_ready, wb_cyc, wb_stb, busy}, {1'b0, 1'b1, 1'b1, 1'b1});
    check("bp_first_adr", wb_adr, BASE + 32'd4);
    job_valid = 1'b0;
    wait_res(c);
    check("bp_second_data", res_data, vecs[0].res);
    take_res();

    // Reset pulse while polling a core that never finishes
    valid_on = 0;
    start_job(0);
    repeat (14) @(negedge clk);
    check("rst_in_poll", {wb_stb, wb_we, wb_adr}, {1'b1, 1'b0, BASE + 32'd40});
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_outputs("midrst");
    bad = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (res_valid || wb_cyc || !job_ready) bad = 1'b1;
    end
    check("midrst_quiet", {63'd0, bad}, 64'd0);

`ifdef DES3_WBM_TIMEOUT_EN
    valid_on = 0;
    start_job(1);
    wait_res(c);
    check("to_cycle", c, 20);
    check("to_flags", {res_err, wb_cyc}, {1'b1, 1'b0});
    check("to_data", res_data, 64'd0);
    c = 0;
    foreach (log_q[j]) if (!log_q[j].we && log_q[j].adr == BASE + 32'd40) c++;
    check("to_poll_reads", c, 8);
    take_res();
`endif

    run_vec(1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
